// File: rtl/rs_station_pkg.sv
// Shared definitions for the reservation station and its age selector:
// default widths, ALU/branch opcode encodings and CDB packing order.
package rs_station_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ROB_W_DEF  = 4;
    localparam int OP_W_DEF   = 6;

    // Packed CDB buses carry channel 0 in the least significant slice.
    localparam int CDB_CH0_LSB = 0;

    typedef enum logic [5:0] {
        OP_ADD  = 6'h00,
        OP_SUB  = 6'h01,
        OP_AND  = 6'h02,
        OP_OR   = 6'h03,
        OP_XOR  = 6'h04,
        OP_SLL  = 6'h05,
        OP_SRL  = 6'h06,
        OP_SRA  = 6'h07,
        OP_SLT  = 6'h08,
        OP_SLTU = 6'h09,
        OP_BEQ  = 6'h10,
        OP_BNE  = 6'h11,
        OP_BLT  = 6'h12,
        OP_BGE  = 6'h13
    } alu_op_e;

    // Bit offset of channel ch in a packed CDB bus whose slices are w wide.
    function automatic int cdb_lsb(input int ch, input int w);
        return CDB_CH0_LSB + ch * w;
    endfunction

endpackage

// File: rtl/rs_age_select.sv
// Age matrix with oldest-ready selection. Row i, bit j set means entry i
// was dispatched before entry j. Rows of idle entries may hold stale bits;
// they are harmless because only ready (hence busy) rows take part.
module rs_age_select
    import rs_station_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [DEPTH-1:0] i_alloc_oh,
    input  logic [DEPTH-1:0] i_busy,
    input  logic [DEPTH-1:0] i_ready,
    output logic [DEPTH-1:0] o_grant,
    output logic             o_any_ready
);

    logic [DEPTH-1:0] r_older [DEPTH];

    // Record the new slot as younger than every currently busy entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_older[i] <= '0;
            end
        end else if (i_en) begin
            if (i_clr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_older[i] <= '0;
                end
            end else begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (i_alloc_oh[s]) begin
                        for (int x = 0; x < DEPTH; x++) begin
                            r_older[x][s] <= i_busy[x];
                            r_older[s][x] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Grant the ready entry that no other ready entry is older than.
    always_comb begin
        o_grant = '0;
        for (int j = 0; j < DEPTH; j++) begin
            o_grant[j] = i_ready[j];
            for (int i = 0; i < DEPTH; i++) begin
                if (i_ready[i] && r_older[i][j]) begin
                    o_grant[j] = 1'b0;
                end
            end
        end
    end

    assign o_any_ready = |i_ready;

endmodule

// File: rtl/rs_station.sv
// Reservation station between dispatch and the ALU: free-slot allocation,
// N-way CDB wakeup with dispatch bypass, oldest-first issue into a
// registered valid/ready stage, and an occupancy count.
module rs_station
    import rs_station_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int CDB_N  = 2,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ROB_W  = ROB_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_rdy,
    input  logic                       i_clr,
    input  logic                       i_disp_valid,
    output logic                       o_disp_ready,
    input  logic [OP_W-1:0]            i_disp_op,
    input  logic                       i_disp_qj_vld,
    input  logic                       i_disp_qk_vld,
    input  logic [DATA_W-1:0]          i_disp_vj,
    input  logic [DATA_W-1:0]          i_disp_vk,
    input  logic [DATA_W-1:0]          i_disp_imm,
    input  logic [DATA_W-1:0]          i_disp_pc,
    input  logic [ROB_W-1:0]           i_disp_rob,
    input  logic [CDB_N-1:0]           i_cdb_valid,
    input  logic [CDB_N*ROB_W-1:0]     i_cdb_rob,
    input  logic [CDB_N*DATA_W-1:0]    i_cdb_value,
    output logic                       o_iss_valid,
    input  logic                       i_iss_ready,
    output logic [OP_W-1:0]            o_iss_op,
    output logic [DATA_W-1:0]          o_iss_vj,
    output logic [DATA_W-1:0]          o_iss_vk,
    output logic [DATA_W-1:0]          o_iss_imm,
    output logic [DATA_W-1:0]          o_iss_pc,
    output logic [ROB_W-1:0]           o_iss_rob,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_qj_vld;
    logic [DEPTH-1:0]  r_qk_vld;
    logic [ROB_W-1:0]  r_qj  [DEPTH];
    logic [ROB_W-1:0]  r_qk  [DEPTH];
    logic [DATA_W-1:0] r_vj  [DEPTH];
    logic [DATA_W-1:0] r_vk  [DEPTH];
    logic [DATA_W-1:0] r_imm [DEPTH];
    logic [DATA_W-1:0] r_pc  [DEPTH];
    logic [ROB_W-1:0]  r_rob [DEPTH];
    logic [OP_W-1:0]   r_op  [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic              r_iss_valid;

    logic              w_free_found;
    logic [IDX_W-1:0]  w_free_idx;
    logic              w_accept;
    logic [DEPTH-1:0]  w_alloc_oh;
    logic              w_bj_hit;
    logic              w_bk_hit;
    logic [DATA_W-1:0] w_bj_val;
    logic [DATA_W-1:0] w_bk_val;
    logic [DEPTH-1:0]  w_wj_hit;
    logic [DEPTH-1:0]  w_wk_hit;
    logic [DATA_W-1:0] w_wj_val [DEPTH];
    logic [DATA_W-1:0] w_wk_val [DEPTH];
    logic [DEPTH-1:0]  w_ready;
    logic [DEPTH-1:0]  w_grant;
    logic              w_any_ready;
    logic              w_stage_open;
    logic              w_take;
    logic [DEPTH-1:0]  w_iss_oh;
    logic [OP_W-1:0]   w_sel_op;
    logic [DATA_W-1:0] w_sel_vj;
    logic [DATA_W-1:0] w_sel_vk;
    logic [DATA_W-1:0] w_sel_imm;
    logic [DATA_W-1:0] w_sel_pc;
    logic [ROB_W-1:0]  w_sel_rob;

    // Lowest-index idle slot; the descending scan lets the lowest hit win.
    always_comb begin
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_found = 1'b1;
                w_free_idx   = IDX_W'(i);
            end
        end
    end

    assign o_disp_ready = (r_count < CNT_W'(DEPTH));
    assign w_accept     = i_rdy & ~i_clr & i_disp_valid & o_disp_ready;
    assign w_alloc_oh   = (w_accept && w_free_found) ? (DEPTH'(1) << w_free_idx) : '0;

    // Same-cycle CDB match for dispatched operands; lowest channel wins.
    always_comb begin
        w_bj_hit = 1'b0;
        w_bk_hit = 1'b0;
        w_bj_val = '0;
        w_bk_val = '0;
        for (int c = CDB_N-1; c >= 0; c--) begin
            if (i_cdb_valid[c] && i_cdb_rob[cdb_lsb(c, ROB_W) +: ROB_W] == i_disp_vj[ROB_W-1:0]) begin
                w_bj_hit = 1'b1;
                w_bj_val = i_cdb_value[cdb_lsb(c, DATA_W) +: DATA_W];
            end
            if (i_cdb_valid[c] && i_cdb_rob[cdb_lsb(c, ROB_W) +: ROB_W] == i_disp_vk[ROB_W-1:0]) begin
                w_bk_hit = 1'b1;
                w_bk_val = i_cdb_value[cdb_lsb(c, DATA_W) +: DATA_W];
            end
        end
    end

    // Wakeup match for every waiting operand; lowest channel wins.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wj_hit[i] = 1'b0;
            w_wk_hit[i] = 1'b0;
            w_wj_val[i] = '0;
            w_wk_val[i] = '0;
            for (int c = CDB_N-1; c >= 0; c--) begin
                if (i_cdb_valid[c] && r_busy[i] && r_qj_vld[i] &&
                    i_cdb_rob[cdb_lsb(c, ROB_W) +: ROB_W] == r_qj[i]) begin
                    w_wj_hit[i] = 1'b1;
                    w_wj_val[i] = i_cdb_value[cdb_lsb(c, DATA_W) +: DATA_W];
                end
                if (i_cdb_valid[c] && r_busy[i] && r_qk_vld[i] &&
                    i_cdb_rob[cdb_lsb(c, ROB_W) +: ROB_W] == r_qk[i]) begin
                    w_wk_hit[i] = 1'b1;
                    w_wk_val[i] = i_cdb_value[cdb_lsb(c, DATA_W) +: DATA_W];
                end
            end
        end
    end

    assign w_ready = r_busy & ~r_qj_vld & ~r_qk_vld;

    rs_age_select #(
        .DEPTH (DEPTH)
    ) u_age_select (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_en        (i_rdy),
        .i_clr       (i_clr),
        .i_alloc_oh  (w_alloc_oh),
        .i_busy      (r_busy),
        .i_ready     (w_ready),
        .o_grant     (w_grant),
        .o_any_ready (w_any_ready)
    );

    assign w_stage_open = ~r_iss_valid | i_iss_ready;
    assign w_take       = i_rdy & ~i_clr & w_stage_open & w_any_ready;
    assign w_iss_oh     = w_take ? w_grant : '0;

    // One-hot mux of the granted entry's payload.
    always_comb begin
        w_sel_op  = '0;
        w_sel_vj  = '0;
        w_sel_vk  = '0;
        w_sel_imm = '0;
        w_sel_pc  = '0;
        w_sel_rob = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_sel_op  = r_op[i];
                w_sel_vj  = r_vj[i];
                w_sel_vk  = r_vk[i];
                w_sel_imm = r_imm[i];
                w_sel_pc  = r_pc[i];
                w_sel_rob = r_rob[i];
            end
        end
    end

    // Entry control bits: allocate, wake, and release on issue.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy   <= '0;
            r_qj_vld <= '0;
            r_qk_vld <= '0;
        end else if (i_rdy) begin
            if (i_clr) begin
                r_busy <= '0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_alloc_oh[i]) begin
                        r_busy[i]   <= 1'b1;
                        r_qj_vld[i] <= i_disp_qj_vld & ~w_bj_hit;
                        r_qk_vld[i] <= i_disp_qk_vld & ~w_bk_hit;
                    end else begin
                        if (w_iss_oh[i]) begin
                            r_busy[i] <= 1'b0;
                        end
                        if (w_wj_hit[i]) begin
                            r_qj_vld[i] <= 1'b0;
                        end
                        if (w_wk_hit[i]) begin
                            r_qk_vld[i] <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Entry payload: written on allocation, operands refreshed on wakeup.
    always_ff @(posedge i_clk) begin
        if (i_rdy && !i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alloc_oh[i]) begin
                    r_op[i]  <= i_disp_op;
                    r_imm[i] <= i_disp_imm;
                    r_pc[i]  <= i_disp_pc;
                    r_rob[i] <= i_disp_rob;
                    r_qj[i]  <= i_disp_vj[ROB_W-1:0];
                    r_qk[i]  <= i_disp_vk[ROB_W-1:0];
                    r_vj[i]  <= (i_disp_qj_vld && w_bj_hit) ? w_bj_val : i_disp_vj;
                    r_vk[i]  <= (i_disp_qk_vld && w_bk_hit) ? w_bk_val : i_disp_vk;
                end else begin
                    if (w_wj_hit[i]) begin
                        r_vj[i] <= w_wj_val[i];
                    end
                    if (w_wk_hit[i]) begin
                        r_vk[i] <= w_wk_val[i];
                    end
                end
            end
        end
    end

    // Issue stage: load when open and a candidate exists, hold when stalled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_iss_valid <= 1'b0;
            o_iss_op    <= '0;
            o_iss_vj    <= '0;
            o_iss_vk    <= '0;
            o_iss_imm   <= '0;
            o_iss_pc    <= '0;
            o_iss_rob   <= '0;
        end else if (i_rdy) begin
            if (i_clr) begin
                r_iss_valid <= 1'b0;
            end else if (w_stage_open) begin
                r_iss_valid <= w_any_ready;
                if (w_any_ready) begin
                    o_iss_op  <= w_sel_op;
                    o_iss_vj  <= w_sel_vj;
                    o_iss_vk  <= w_sel_vk;
                    o_iss_imm <= w_sel_imm;
                    o_iss_pc  <= w_sel_pc;
                    o_iss_rob <= w_sel_rob;
                end
            end
        end
    end

    assign o_iss_valid = r_iss_valid;

    // Occupancy: +accept -issue, both possible in one cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_rdy) begin
            if (i_clr) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(w_accept) - CNT_W'(w_take);
            end
        end
    end

    assign o_count = r_count;

endmodule

// File: tb/tb_rs_station.sv
// Bench for rs_station: directed scenarios plus a randomized stretch, all
// compared every cycle against an in-order queue model of the station.
module tb_rs_station;
    import rs_station_pkg::*;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy, clr, disp_valid, disp_ready;
    logic [5:0]  disp_op;
    logic        disp_qj_vld, disp_qk_vld;
    logic [31:0] disp_vj, disp_vk, disp_imm, disp_pc;
    logic [3:0]  disp_rob;
    logic [1:0]  cdb_valid;
    logic [7:0]  cdb_rob;
    logic [63:0] cdb_value;
    logic        iss_valid, iss_ready;
    logic [5:0]  iss_op;
    logic [31:0] iss_vj, iss_vk, iss_imm, iss_pc;
    logic [3:0]  iss_rob;
    logic [4:0]  count;

    rs_station #(.DEPTH(DEPTH), .CDB_N(2), .DATA_W(32), .ROB_W(4), .OP_W(6)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rdy(rdy), .i_clr(clr),
        .i_disp_valid(disp_valid), .o_disp_ready(disp_ready), .i_disp_op(disp_op),
        .i_disp_qj_vld(disp_qj_vld), .i_disp_qk_vld(disp_qk_vld),
        .i_disp_vj(disp_vj), .i_disp_vk(disp_vk), .i_disp_imm(disp_imm),
        .i_disp_pc(disp_pc), .i_disp_rob(disp_rob),
        .i_cdb_valid(cdb_valid), .i_cdb_rob(cdb_rob), .i_cdb_value(cdb_value),
        .o_iss_valid(iss_valid), .i_iss_ready(iss_ready), .o_iss_op(iss_op),
        .o_iss_vj(iss_vj), .o_iss_vk(iss_vk), .o_iss_imm(iss_imm),
        .o_iss_pc(iss_pc), .o_iss_rob(iss_rob), .o_count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic        qj_vld;
        logic        qk_vld;
        logic [3:0]  qj;
        logic [3:0]  qk;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  rob;
    } ent_t;

    // Model: queue in dispatch order (front = oldest) plus the issue stage.
    ent_t        mq[$];
    ent_t        m_iss;
    bit          m_iss_valid;
    bit          m_loaded;
    logic [3:0]  obs_rob[$];
    logic [31:0] obs_vj[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    function automatic bit cdb_hit(input logic [3:0] tag, output logic [31:0] val);
        bit found = 0;
        val = '0;
        for (int c = 0; c < 2; c++) begin
            if (!found && cdb_valid[c] && cdb_rob[c*4 +: 4] == tag) begin
                found = 1;
                val   = cdb_value[c*32 +: 32];
            end
        end
        return found;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_iss       = '0;
        m_iss_valid = 0;
        m_loaded    = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        int          sel;
        bit          acc, open;
        logic [31:0] v;
        ent_t        e;
        m_loaded = 0;
        if (!rdy) return;
        if (clr) begin
            mq.delete();
            m_iss_valid = 0;
            return;
        end
        sel = -1;
        foreach (mq[k]) if (sel < 0 && !mq[k].qj_vld && !mq[k].qk_vld) sel = k;
        acc  = disp_valid && (mq.size() < DEPTH);
        open = !m_iss_valid || iss_ready;
        if (open) begin
            if (sel >= 0) begin
                m_iss       = mq[sel];
                m_iss_valid = 1;
                m_loaded    = 1;
            end else begin
                m_iss_valid = 0;
            end
        end
        foreach (mq[k]) begin
            if (mq[k].qj_vld && cdb_hit(mq[k].qj, v)) begin mq[k].vj = v; mq[k].qj_vld = 0; end
            if (mq[k].qk_vld && cdb_hit(mq[k].qk, v)) begin mq[k].vk = v; mq[k].qk_vld = 0; end
        end
        if (open && sel >= 0) mq.delete(sel);
        if (acc) begin
            e.op = disp_op; e.imm = disp_imm; e.pc = disp_pc; e.rob = disp_rob;
            e.qj = disp_vj[3:0]; e.qk = disp_vk[3:0];
            e.vj = disp_vj; e.vk = disp_vk;
            e.qj_vld = disp_qj_vld; e.qk_vld = disp_qk_vld;
            if (e.qj_vld && cdb_hit(e.qj, v)) begin e.vj = v; e.qj_vld = 0; end
            if (e.qk_vld && cdb_hit(e.qk, v)) begin e.vk = v; e.qk_vld = 0; end
            mq.push_back(e);
        end
    endtask

    task automatic check_all();
        chk("iss_valid",  {63'd0, iss_valid}, {63'd0, m_iss_valid});
        chk("count",      {59'd0, count}, 64'(mq.size()));
        chk("disp_ready", {63'd0, disp_ready}, {63'd0, (mq.size() < DEPTH)});
        chk("iss_rob",    {60'd0, iss_rob}, {60'd0, m_iss.rob});
        chk("iss_op",     {58'd0, iss_op},  {58'd0, m_iss.op});
        chk("iss_vj",     {32'd0, iss_vj},  {32'd0, m_iss.vj});
        chk("iss_vk",     {32'd0, iss_vk},  {32'd0, m_iss.vk});
        chk("iss_imm",    {32'd0, iss_imm}, {32'd0, m_iss.imm});
        chk("iss_pc",     {32'd0, iss_pc},  {32'd0, m_iss.pc});
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (m_loaded) begin
            obs_rob.push_back(iss_rob);
            obs_vj.push_back(iss_vj);
        end
        check_all();
    endtask

    task automatic idle_inputs();
        disp_valid = 0; disp_qj_vld = 0; disp_qk_vld = 0;
        cdb_valid = '0; cdb_rob = '0; cdb_value = '0; clr = 0;
    endtask

    task automatic set_disp(input bit qjv, input bit qkv, input logic [31:0] vj,
                            input logic [31:0] vk, input logic [3:0] rob);
        disp_valid = 1; disp_qj_vld = qjv; disp_qk_vld = qkv;
        disp_vj = vj; disp_vk = vk; disp_rob = rob;
        disp_op = OP_ADD; disp_imm = $urandom; disp_pc = $urandom;
    endtask

    initial begin
        rst_n = 0; rdy = 1; iss_ready = 1;
        disp_op = '0; disp_vj = '0; disp_vk = '0; disp_imm = '0; disp_pc = '0; disp_rob = '0;
        idle_inputs();
        model_reset();
        #12;
        chk("rst_iss_valid",  {63'd0, iss_valid}, 64'd0);
        chk("rst_count",      {59'd0, count}, 64'd0);
        chk("rst_disp_ready", {63'd0, disp_ready}, 64'd1);
        chk("rst_iss_vj",     {32'd0, iss_vj}, 64'd0);
        rst_n = 1;

        // Fully ready ADD: issue two edges after dispatch.
        set_disp(0, 0, 32'd5, 32'd7, 4'd3);
        step();
        idle_inputs();
        step();
        chk("add_valid", {63'd0, iss_valid}, 64'd1);
        chk("add_vj",    {32'd0, iss_vj}, 64'd5);
        chk("add_vk",    {32'd0, iss_vk}, 64'd7);
        chk("add_rob",   {60'd0, iss_rob}, 64'd3);
        chk("add_count", {59'd0, count}, 64'd0);
        step();

        // Pending on tag 9 then ready; broadcast tag 9 on channel 1.
        obs_rob.delete(); obs_vj.delete();
        set_disp(1, 0, 32'd9, 32'd1, 4'd1);
        step();
        set_disp(0, 0, 32'd2, 32'd3, 4'd2);
        step();
        idle_inputs();
        cdb_valid = 2'b10; cdb_rob = {4'd9, 4'd0}; cdb_value = {32'h55, 32'h0};
        step();
        idle_inputs();
        repeat (4) step();
        chk("wake_n",    64'(obs_rob.size()), 64'd2);
        if (obs_rob.size() >= 2) begin
            chk("wake_first",  {60'd0, obs_rob[0]}, 64'd2);
            chk("wake_second", {60'd0, obs_rob[1]}, 64'd1);
            chk("wake_vj",     {32'd0, obs_vj[1]}, 64'h55);
        end

        // Dispatch bypass: channel 0 broadcasts the pending tag that cycle.
        set_disp(1, 0, 32'd4, 32'd8, 4'd6);
        cdb_valid = 2'b01; cdb_rob = {4'd0, 4'd4}; cdb_value = {32'h0, 32'hAA};
        step();
        idle_inputs();
        step();
        chk("byp_valid", {63'd0, iss_valid}, 64'd1);
        chk("byp_vj",    {32'd0, iss_vj}, 64'hAA);
        step();

        // Fill with the issue stage stalled.
        iss_ready = 0;
        for (int i = 0; i < 20; i++) begin
            set_disp(0, 0, $urandom, $urandom, 4'(i));
            step();
        end
        idle_inputs();
        chk("full_ready", {63'd0, disp_ready}, 64'd0);
        chk("full_count", {59'd0, count}, 64'd16);
        repeat (2) step();
        chk("full_hold",  {60'd0, iss_rob}, 64'd0);
        obs_rob.delete(); obs_vj.delete();
        iss_ready = 1;
        repeat (20) step();
        chk("drain_n", 64'(obs_rob.size()), 64'd16);
        for (int k = 0; k < 16 && k < obs_rob.size(); k++)
            chk("drain_order", {60'd0, obs_rob[k]}, 64'((k + 1) % 16));
        chk("drain_count", {59'd0, count}, 64'd0);

        // Flush with a concurrent dispatch.
        iss_ready = 0;
        for (int i = 0; i < 8; i++) begin
            set_disp(0, 0, $urandom, $urandom, 4'(i));
            step();
        end
        set_disp(0, 0, 32'd1, 32'd1, 4'd9);
        clr = 1;
        step();
        idle_inputs();
        chk("clr_count", {59'd0, count}, 64'd0);
        chk("clr_valid", {63'd0, iss_valid}, 64'd0);
        step();
        chk("clr_nodisp", {59'd0, count}, 64'd0);

        // Freeze with rdy low while a matching broadcast and dispatch are present.
        set_disp(0, 0, 32'd1, 32'd1, 4'd5);  step();
        set_disp(1, 0, 32'd2, 32'd1, 4'd6);  step();
        set_disp(0, 1, 32'd1, 32'd3, 4'd7);  step();
        idle_inputs(); step();
        rdy = 0; iss_ready = 1;
        set_disp(0, 0, 32'd1, 32'd1, 4'd8);
        cdb_valid = 2'b11; cdb_rob = {4'd3, 4'd2}; cdb_value = {32'h33, 32'h22};
        repeat (3) begin
            step();
            chk("frz_count", {59'd0, count}, 64'd2);
            chk("frz_rob",   {60'd0, iss_rob}, 64'd5);
            chk("frz_valid", {63'd0, iss_valid}, 64'd1);
        end
        rdy = 1; idle_inputs();
        step();
        cdb_valid = 2'b11; cdb_rob = {4'd3, 4'd2}; cdb_value = {32'h33, 32'h22};
        step();
        idle_inputs();
        step();
        iss_ready = 0;
        step();
        chk("pre_rst_valid", {63'd0, iss_valid}, 64'd1);
        chk("pre_rst_rob",   {60'd0, iss_rob}, 64'd6);
        #3 rst_n = 0;
        #1;
        chk("arst_valid", {63'd0, iss_valid}, 64'd0);
        chk("arst_count", {59'd0, count}, 64'd0);
        model_reset();
        #2 rst_n = 1;

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            rdy        = ($urandom_range(15) != 0);
            clr        = ($urandom_range(79) == 0);
            iss_ready  = ($urandom_range(3) != 0);
            disp_valid = ($urandom_range(1) == 0);
            disp_qj_vld = ($urandom_range(2) == 0);
            disp_qk_vld = ($urandom_range(2) == 0);
            disp_vj  = $urandom; disp_vk = $urandom;
            disp_imm = $urandom; disp_pc = $urandom;
            disp_rob = 4'($urandom); disp_op = 6'($urandom);
            cdb_valid = 2'($urandom);
            cdb_rob   = 8'($urandom);
            cdb_value = {$urandom, $urandom};
            step();
        end
        idle_inputs(); rdy = 1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
